// File: rtl/score_sequencer.sv
// -----------------------------------------------------------------------------
// score_sequencer
// Plays a song held in a synchronous-read score ROM. Each step fetches one
// {note, duration} entry and drives the note generator for `duration` cycles.
// Then it inserts a fixed silent articulation gap before the next entry.
// Supports start, stop, pause and looping.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   start_i        one-cycle pulse, begin playback at entry 0 (ignored while busy)
//   stop_i         one-cycle pulse, abort playback (wins over start_i)
//   pause_i        level, freezes the PLAY/GAP counters while high
//   loop_en_i      level, restart at entry 0 when the end of the score is reached
//   rom_addr_o     score ROM address (registered)
//   rom_data_i     {note[31:24], duration[23:0]}, valid one cycle after rom_addr_o
//   note_o         note number to the note generator (registered)
//   duration_o     current note duration in clk cycles (registered)
//   play_enable_o  note generator enable (registered)
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse on a normal end of score
//   cur_index_o    index of the entry being played
// -----------------------------------------------------------------------------
module score_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned GAP_CYCLES = 600000,
  parameter logic [7:0]  END_CODE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic              loop_en_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [7:0]        note_o,
  output logic [23:0]       duration_o,
  output logic              play_enable_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] cur_index_o
);

  localparam int unsigned     GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned     GAP_LAST_INT = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_LAST_INT);
  localparam logic            GAP_EN       = (GAP_CYCLES != 0);
  localparam logic [ADDR_W-1:0] IDX_LAST   = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] cur_index_q, cur_index_d;
  logic [7:0]        note_q, note_d;
  logic [23:0]       dur_q, dur_d;
  logic [23:0]       dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              pe_q, pe_d;

  logic [7:0]        rom_note_s;
  logic [23:0]       rom_dur_s;
  state_e            end_state_s, adv_state_s;
  logic [ADDR_W-1:0] end_index_s, adv_index_s;

  assign rom_note_s = rom_data_i[31:24];
  assign rom_dur_s  = rom_data_i[23:0];

  // End-of-score and advance targets, shared by LOAD, PLAY and GAP exits.
  always_comb begin
    if (loop_en_i) begin
      end_state_s = S_FETCH;
      end_index_s = {ADDR_W{1'b0}};
    end else begin
      end_state_s = S_DONE;
      end_index_s = index_q;
    end
    // The last ROM entry never wraps implicitly; it is treated as end of score.
    if (index_q == IDX_LAST) begin
      adv_state_s = end_state_s;
      adv_index_s = end_index_s;
    end else begin
      adv_state_s = S_FETCH;
      adv_index_s = index_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      index_q     <= {ADDR_W{1'b0}};
      cur_index_q <= {ADDR_W{1'b0}};
      note_q      <= 8'd0;
      dur_q       <= 24'd0;
      dur_cnt_q   <= 24'd0;
      gap_cnt_q   <= {GAP_W{1'b0}};
      pe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cur_index_q <= cur_index_d;
      note_q      <= note_d;
      dur_q       <= dur_d;
      dur_cnt_q   <= dur_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pe_q        <= pe_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cur_index_d = cur_index_q;
    note_d      = note_q;
    dur_d       = dur_q;
    dur_cnt_d   = dur_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pe_d        = pe_q;

    if (stop_i) begin
      state_d     = S_IDLE;
      index_d     = {ADDR_W{1'b0}};
      cur_index_d = {ADDR_W{1'b0}};
      note_d      = 8'd0;
      dur_d       = 24'd0;
      dur_cnt_d   = 24'd0;
      gap_cnt_d   = {GAP_W{1'b0}};
      pe_d        = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pe_d = 1'b0;
          if (start_i) begin
            state_d = S_FETCH;
            index_d = {ADDR_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (rom_note_s == END_CODE) begin
            state_d = end_state_s;
            index_d = end_index_s;
          end else if (rom_dur_s == 24'd0) begin
            state_d = adv_state_s;
            index_d = adv_index_s;
          end else begin
            note_d      = rom_note_s;
            dur_d       = rom_dur_s;
            cur_index_d = index_q;
            pe_d        = 1'b1;
            dur_cnt_d   = 24'd0;
            state_d     = S_PLAY;
          end
        end
        S_PLAY: begin
          // A cycle counts toward the note only when play_enable was actually
          // high in it, so the enable is high for exactly `duration` cycles.
          if (pe_q && (dur_cnt_q == (dur_q - 24'd1))) begin
            pe_d      = 1'b0;
            dur_cnt_d = 24'd0;
            gap_cnt_d = {GAP_W{1'b0}};
            if (GAP_EN) begin
              state_d = S_GAP;
            end else begin
              state_d = adv_state_s;
              index_d = adv_index_s;
            end
          end else begin
            pe_d = !pause_i;
            if (pe_q) begin
              dur_cnt_d = dur_cnt_q + 24'd1;
            end else begin
              dur_cnt_d = dur_cnt_q;
            end
          end
        end
        S_GAP: begin
          pe_d = 1'b0;
          if (pause_i) begin
            gap_cnt_d = gap_cnt_q;
          end else if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = {GAP_W{1'b0}};
            state_d   = adv_state_s;
            index_d   = adv_index_s;
          end else begin
            gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          pe_d    = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          pe_d    = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs: status flags decoded from the state register, datapath registers driven straight out.
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = (state_q == S_DONE);
    rom_addr_o    = index_q;
    cur_index_o   = cur_index_q;
    note_o        = note_q;
    duration_o    = dur_q;
    play_enable_o = pe_q;
  end

endmodule

// File: tb/tb_score_sequencer.sv
module tb_score_sequencer;

  localparam int AW   = 4;
  localparam int GAP  = 4;
  localparam int MAXC = 700;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, pause, loop_en;
  logic [AW-1:0] rom_addr, cur_index;
  logic [31:0]   rom_data;
  logic [7:0]    note;
  logic [23:0]   duration;
  logic          play_enable, busy, done;
  logic [31:0]   rom [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  score_sequencer #(.ADDR_W(AW), .GAP_CYCLES(GAP), .END_CODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .loop_en_i(loop_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .note_o(note), .duration_o(duration), .play_enable_o(play_enable),
    .busy_o(busy), .done_o(done), .cur_index_o(cur_index)
  );

  // inp = {rst, start, stop, pause, loop_en}; exp = {play_enable, busy, done}
  typedef struct {
    int         n;
    logic [4:0] inp;
    logic [2:0] exp;
    logic [7:0] nt;
  } vec_t;
  vec_t tbl[$];

  // reference timeline for randomized runs
  bit          pz   [MAXC];
  bit          e_pe [MAXC];
  bit          e_bz [MAXC];
  bit          e_dn [MAXC];
  logic [7:0]  e_nt [MAXC];
  logic [23:0] e_du [MAXC];
  logic [3:0]  e_ci [MAXC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [7:0] n, input logic [23:0] d);
    return {n, d};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = ent(8'hFF, 24'd0);
  endtask

  task automatic basic_rom();
    clear_rom();
    rom[0] = ent(8'd12, 24'd5);
    rom[1] = ent(8'd8, 24'd3);
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs just after the edge, sample at the falling edge.
  task automatic step(input logic st, input logic sp, input logic pa);
    @(posedge clk);
    #1;
    start = st; stop = sp; pause = pa;
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, " pe"}, 64'(play_enable), 64'd0);
    chk({tag, " note"}, 64'(note), 64'd0);
    chk({tag, " dur"}, 64'(duration), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " addr"}, 64'(rom_addr), 64'd0);
    chk({tag, " cur"}, 64'(cur_index), 64'd0);
  endtask

  // Builds the expected per-cycle outputs from the score and the pause pattern,
  // with start in cycle 0. Returns the cycle carrying the done pulse.
  task automatic build_model(output int endc);
    int t, idx, n, c, played, g, first;
    logic [7:0]  nt;
    logic [23:0] d;
    bit fin;
    for (int k = 0; k < MAXC; k++) begin
      e_pe[k] = 1'b0; e_bz[k] = 1'b0; e_dn[k] = 1'b0;
      e_nt[k] = 8'd0; e_du[k] = 24'd0; e_ci[k] = 4'd0;
    end
    t = 1; idx = 0; fin = 1'b0; endc = 0;
    while (!fin) begin
      e_bz[t] = 1'b1; e_bz[t+1] = 1'b1;
      nt = rom[idx][31:24];
      d  = rom[idx][23:0];
      n  = t + 2;
      if (nt == 8'hFF) begin
        e_dn[n] = 1'b1; e_bz[n] = 1'b1; endc = n; fin = 1'b1;
      end else begin
        if (d != 24'd0) begin
          first = t + 2;
          for (int k = first; k < MAXC; k++) begin
            e_nt[k] = nt; e_du[k] = d; e_ci[k] = 4'(idx);
          end
          c = first - 1; played = 0;
          while (played < int'(d)) begin
            c++;
            e_bz[c] = 1'b1;
            e_pe[c] = (c == first) || !pz[c-1];
            if (e_pe[c]) played++;
          end
          g = 0;
          while (g < GAP) begin
            c++;
            e_bz[c] = 1'b1;
            if (!pz[c]) g++;
          end
          n = c + 1;
        end
        if (idx == 15) begin
          e_dn[n] = 1'b1; e_bz[n] = 1'b1; endc = n; fin = 1'b1;
        end else begin
          idx++;
          t = n;
        end
      end
    end
  endtask

  task automatic run_random(input int trial);
    int len, endc;
    logic [23:0] d;
    clear_rom();
    len = $urandom_range(1, 16);
    for (int i = 0; i < len; i++) begin
      d = ($urandom_range(0, 4) == 0) ? 24'd0 : 24'($urandom_range(1, 6));
      rom[i] = ent(8'($urandom_range(0, 254)), d);
    end
    for (int c = 0; c < MAXC; c++) pz[c] = (c < 400) && ($urandom_range(0, 3) == 0);
    build_model(endc);
    do_reset();
    for (int c = 0; c <= endc + 2; c++) begin
      step((c == 0) ? 1'b1 : 1'b0, 1'b0, pz[c]);
      chk($sformatf("rand%0d c%0d {pe,busy,done,cur,note,dur}", trial, c),
          64'({play_enable, busy, done, cur_index, note, duration}),
          64'({e_pe[c], e_bz[c], e_dn[c], e_ci[c], e_nt[c], e_du[c]}));
    end
  endtask

  initial begin
    int rise, c;
    bit seen, seen1;
    logic [4:0] iv;
    logic       rst_v;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    basic_rom();

    // score {(12,5),(8,3),END}, GAP=4
    tbl.push_back('{32'd2, 5'b10000, 3'b000, 8'd0});
    tbl.push_back('{32'd1, 5'b01000, 3'b000, 8'd0});
    tbl.push_back('{32'd2, 5'b00000, 3'b010, 8'd0});
    tbl.push_back('{32'd5, 5'b00000, 3'b110, 8'd12});
    tbl.push_back('{32'd6, 5'b00000, 3'b010, 8'd12});
    tbl.push_back('{32'd3, 5'b00000, 3'b110, 8'd8});
    tbl.push_back('{32'd6, 5'b00000, 3'b010, 8'd8});
    tbl.push_back('{32'd1, 5'b00000, 3'b011, 8'd8});
    tbl.push_back('{32'd2, 5'b00000, 3'b000, 8'd8});
    // pause for 10 cycles after 2 of 5 played cycles
    tbl.push_back('{32'd2, 5'b10000, 3'b000, 8'd0});
    tbl.push_back('{32'd1, 5'b01000, 3'b000, 8'd0});
    tbl.push_back('{32'd2, 5'b00000, 3'b010, 8'd0});
    tbl.push_back('{32'd1, 5'b00000, 3'b110, 8'd12});
    tbl.push_back('{32'd1, 5'b00010, 3'b110, 8'd12});
    tbl.push_back('{32'd9, 5'b00010, 3'b010, 8'd12});
    tbl.push_back('{32'd1, 5'b00000, 3'b010, 8'd12});
    tbl.push_back('{32'd3, 5'b00000, 3'b110, 8'd12});
    tbl.push_back('{32'd6, 5'b00000, 3'b010, 8'd12});
    tbl.push_back('{32'd3, 5'b00000, 3'b110, 8'd8});
    // pause held from IDLE: start accepted, playback freezes after first PLAY cycle
    tbl.push_back('{32'd2, 5'b10000, 3'b000, 8'd0});
    tbl.push_back('{32'd1, 5'b01010, 3'b000, 8'd0});
    tbl.push_back('{32'd2, 5'b00010, 3'b010, 8'd0});
    tbl.push_back('{32'd1, 5'b00010, 3'b110, 8'd12});
    tbl.push_back('{32'd4, 5'b00010, 3'b010, 8'd12});
    tbl.push_back('{32'd1, 5'b00000, 3'b010, 8'd12});
    tbl.push_back('{32'd4, 5'b00000, 3'b110, 8'd12});
    tbl.push_back('{32'd2, 5'b00000, 3'b010, 8'd12});

    for (int i = 0; i < tbl.size(); i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        @(posedge clk);
        #1;
        iv = tbl[i].inp;
        {rst_v, start, stop, pause, loop_en} = iv;
        rst_n = !rst_v;
        @(negedge clk);
        chk($sformatf("vec%0d.%0d {pe,busy,done}", i, j),
            64'({play_enable, busy, done}), 64'(tbl[i].exp));
        chk($sformatf("vec%0d.%0d note", i, j), 64'(note), 64'(tbl[i].nt));
      end
    end

    // reset state
    do_reset();
    chk_cleared("reset");

    // looping: END returns to entry 0, no done pulse
    basic_rom();
    do_reset();
    loop_en = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (c = 1; c <= 30; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done) seen = 1'b1;
      if (c == 22) chk("loop addr c22", 64'(rom_addr), 64'd2);
      if (c == 23) chk("loop addr c23", 64'(rom_addr), 64'd0);
      if (c == 25) begin
        chk("loop pe c25", 64'(play_enable), 64'd1);
        chk("loop note c25", 64'(note), 64'd12);
        chk("loop cur c25", 64'(cur_index), 64'd0);
      end
    end
    chk("loop no done", 64'(seen), 64'd0);
    chk("loop busy", 64'(busy), 64'd1);
    loop_en = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("loop stop busy", 64'(busy), 64'd0);

    // zero-duration entry is skipped, adding two cycles of low time
    clear_rom();
    rom[0] = ent(8'd12, 24'd5);
    rom[1] = ent(8'd5, 24'd0);
    rom[2] = ent(8'd8, 24'd3);
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    rise = -1; seen1 = 1'b0;
    for (c = 1; c <= 30; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (cur_index == 4'd1) seen1 = 1'b1;
      if (play_enable && c > 7 && rise < 0) rise = c;
      if (c == 16) begin
        chk("skip cur c16", 64'(cur_index), 64'd2);
        chk("skip note c16", 64'(note), 64'd8);
      end
    end
    chk("skip rise cycle", 64'(rise), 64'd16);
    chk("skip index hidden", 64'(seen1), 64'd0);

    // stop during PLAY, then replay from entry 0
    basic_rom();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 4; c++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("stopP pe before", 64'(play_enable), 64'd1);
    step(1'b0, 1'b0, 1'b0);
    chk_cleared("stopP");
    seen = 1'b0;
    for (c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done || busy) seen = 1'b1;
    end
    chk("stopP quiet", 64'(seen), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b0);
    chk("stopP replay pe", 64'(play_enable), 64'd1);
    chk("stopP replay note", 64'(note), 64'd12);

    // stop during GAP after entry 1
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 17; c++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("stopG addr before", 64'(rom_addr), 64'd1);
    chk("stopG pe before", 64'(play_enable), 64'd0);
    step(1'b0, 1'b0, 1'b0);
    chk_cleared("stopG");
    seen = 1'b0;
    for (c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done) seen = 1'b1;
    end
    chk("stopG no done", 64'(seen), 64'd0);
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b0);
    chk("stopG replay note", 64'(note), 64'd12);
    chk("stopG replay cur", 64'(cur_index), 64'd0);

    // start and stop together in IDLE
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    for (c = 1; c <= 4; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("startstop busy c%0d", c), 64'(busy), 64'd0);
    end

    // start while busy is ignored
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 24; c++) begin
      step((c == 5 || c == 15 || c == 20) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      if (c == 8) chk("busystart pe c8", 64'(play_enable), 64'd0);
      if (c == 14) chk("busystart note c14", 64'({play_enable, note}), 64'({1'b1, 8'd8}));
      if (c == 23) chk("busystart done c23", 64'(done), 64'd1);
      if (c == 24) chk("busystart busy c24", 64'(busy), 64'd0);
    end

    // asynchronous reset in the middle of a note
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (c = 1; c <= 4; c++) step(1'b0, 1'b0, 1'b0);
    chk("async pe before", 64'(play_enable), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_cleared("async");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized scores and pause patterns against the timeline model
    for (int tr = 0; tr < 20; tr++) run_random(tr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
